config_stream_loader: RTL and testbench

- Upstream configuration source for the tile array.
- Accepts a byte stream from a host-side deserializer (UART/SPI front end) over a valid/ready handshake.
- Assembles 8-byte records into (address, data) pairs and drives the shared config_addr / config_data bus broadcast to every pe_tile.
- Tiles have no write strobe; their address matchers latch on address match. The loader therefore parks the bus on a reserved null address whenever it is not writing.

---
 rtl/config_stream_loader_if.sv | 28 ++
 rtl/config_stream_loader.sv | 145 ++++++++++++++
 tb/tb_config_stream_loader.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/config_stream_loader_if.sv
// Byte-stream handshake and config broadcast bus of the config stream loader.
// The host side (deserializer / test driver) uses the master modport; the
// loader uses the slave modport.
interface config_stream_loader_if;

    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] config_addr;
    logic [31:0] config_data;

    modport master (
        output in_byte,
        output in_valid,
        input  in_ready,
        input  config_addr,
        input  config_data
    );

    modport slave (
        input  in_byte,
        input  in_valid,
        output in_ready,
        output config_addr,
        output config_data
    );

endinterface

// File: rtl/config_stream_loader.sv
// Configuration stream loader.
// Takes a byte stream over valid/ready, assembles 8-byte records (address LSB
// first, then data LSB first) and broadcasts each (address, data) pair on the
// shared tile config bus for HOLD_CYCLES cycles. Tiles have no write strobe, so
// the bus is parked on NULL_ADDR at every other time, and at least one null
// cycle separates consecutive records. A record addressed to END_ADDR ends
// configuration; it is never driven onto the bus.
module config_stream_loader #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter logic [31:0] NULL_ADDR   = 32'hFFFF_FFFF,
    parameter logic [31:0] END_ADDR    = 32'hFFFF_FFFE
) (
    input  logic                         clk,
    input  logic                         reset,
    config_stream_loader_if.slave        bus,
    output logic                         busy,
    output logic                         config_done,
    output logic [15:0]                  record_count
);

    localparam logic [7:0] HoldLast = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        StCollect,
        StDrive,
        StGap,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  hold_q, hold_d;
    // Bytes 0..6 of the record; byte 7 is taken straight from in_byte.
    logic [55:0] asm_q, asm_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] record_count_q, record_count_d;

    logic        xfer;
    logic [31:0] rec_addr;
    logic [31:0] rec_data;

    // ready_q is only ever set while in COLLECT, so it alone qualifies a transfer.
    assign xfer     = bus.in_valid & ready_q;
    // Bytes are shifted in from the top, so after 7 shifts byte 0 sits at [7:0].
    assign rec_addr = asm_q[31:0];
    assign rec_data = {bus.in_byte, asm_q[55:32]};

    // Next-state logic for the record FSM and its registered outputs.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        hold_d         = hold_q;
        asm_d          = asm_q;
        addr_d         = addr_q;
        data_d         = data_q;
        done_d         = done_q;
        record_count_d = record_count_q;

        unique case (state_q)
            StCollect: begin
                if (xfer) begin
                    if (idx_q != 3'd7) begin
                        asm_d = {bus.in_byte, asm_q[55:8]};
                        idx_d = idx_q + 3'd1;
                    end else begin
                        idx_d = 3'd0;
                        if (rec_addr == END_ADDR) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else begin
                            addr_d  = rec_addr;
                            data_d  = rec_data;
                            hold_d  = 8'd0;
                            state_d = StDrive;
                        end
                    end
                end
            end
            StDrive: begin
                if (hold_q == HoldLast) begin
                    addr_d  = NULL_ADDR;
                    data_d  = 32'd0;
                    state_d = StGap;
                    if (record_count_q != 16'hFFFF) begin
                        record_count_d = record_count_q + 16'd1;
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            StGap: begin
                state_d = StCollect;
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StCollect;
            end
        endcase

        ready_d = (state_d == StCollect);
        busy_d  = (state_d == StDrive) || (state_d == StGap) ||
                  ((state_d == StCollect) && (idx_d != 3'd0));
    end

    // State and output registers; reset parks the bus and drops any partial record.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StCollect;
            idx_q          <= 3'd0;
            hold_q         <= 8'd0;
            asm_q          <= 56'd0;
            addr_q         <= NULL_ADDR;
            data_q         <= 32'd0;
            ready_q        <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            record_count_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            hold_q         <= hold_d;
            asm_q          <= asm_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            ready_q        <= ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            record_count_q <= record_count_d;
        end
    end

    assign bus.in_ready    = ready_q;
    assign bus.config_addr = addr_q;
    assign bus.config_data = data_q;
    assign busy            = busy_q;
    assign config_done     = done_q;
    assign record_count    = record_count_q;

endmodule

// File: tb/tb_config_stream_loader.sv
// Bench for config_stream_loader: a HOLD_CYCLES=2 instance (A) and a
// HOLD_CYCLES=1 instance (B) share the stimulus, selected by sel. A negedge
// bus monitor turns the broadcast bus into a list of (addr, data, cycles held)
// writes, which is compared against records the bench itself generated.
module tb_config_stream_loader;

    localparam logic [31:0] NULL_A = 32'hFFFF_FFFF;
    localparam logic [31:0] END_A  = 32'hFFFF_FFFE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, sel;
    logic [7:0] tb_byte;
    logic       tb_valid;
    int         tests = 0;
    int         fails = 0;

    config_stream_loader_if if_a ();
    config_stream_loader_if if_b ();

    logic        busy_a, done_a, busy_b, done_b;
    logic [15:0] cnt_a, cnt_b;

    assign if_a.in_byte  = tb_byte;
    assign if_a.in_valid = tb_valid & ~sel;
    assign if_b.in_byte  = tb_byte;
    assign if_b.in_valid = tb_valid & sel;

    config_stream_loader #(.HOLD_CYCLES(2)) dut_a (
        .clk          (clk),
        .reset        (rst_a),
        .bus          (if_a),
        .busy         (busy_a),
        .config_done  (done_a),
        .record_count (cnt_a)
    );

    config_stream_loader #(.HOLD_CYCLES(1)) dut_b (
        .clk          (clk),
        .reset        (rst_b),
        .bus          (if_b),
        .busy         (busy_b),
        .config_done  (done_b),
        .record_count (cnt_b)
    );

    logic        m_ready, m_busy, m_done;
    logic [31:0] m_addr, m_data;
    logic [15:0] m_count;

    assign m_ready = sel ? if_b.in_ready    : if_a.in_ready;
    assign m_addr  = sel ? if_b.config_addr : if_a.config_addr;
    assign m_data  = sel ? if_b.config_data : if_a.config_data;
    assign m_busy  = sel ? busy_b : busy_a;
    assign m_done  = sel ? done_b : done_a;
    assign m_count = sel ? cnt_b  : cnt_a;

    // Bus monitor: each maximal run of one non-null (addr, data) is one write.
    logic [31:0] mon_addr[$];
    logic [31:0] mon_data[$];
    int          mon_len[$];
    int          adj_err = 0;
    logic [31:0] run_addr, run_data;
    int          run_len = 0;

    always @(negedge clk) begin
        if (m_addr !== NULL_A) begin
            if (run_len > 0 && (m_addr !== run_addr || m_data !== run_data)) begin
                mon_addr.push_back(run_addr);
                mon_data.push_back(run_data);
                mon_len.push_back(run_len);
                adj_err++;
                run_len = 0;
            end
            run_addr = m_addr;
            run_data = m_data;
            run_len++;
        end else if (run_len > 0) begin
            mon_addr.push_back(run_addr);
            mon_data.push_back(run_data);
            mon_len.push_back(run_len);
            run_len = 0;
        end
    end

    // Reference model: expected bus writes and count.
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mon_clear();
        mon_addr.delete();
        mon_data.delete();
        mon_len.delete();
        adj_err = 0;
    endtask

    task automatic do_reset(input bit which_b);
        tb_valid = 1'b0;
        if (which_b) rst_b = 1'b0; else rst_a = 1'b0;
        repeat (3) @(negedge clk);
        if (which_b) rst_b = 1'b1; else rst_a = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(m_ready === 1'b1 && m_busy === 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < 200), 32'd1);
    endtask

    // Offers a byte after 'gap' idle cycles and returns once it has transferred.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        tb_valid = 1'b0;
        repeat (gap) @(negedge clk);
        tb_byte  = b;
        tb_valid = 1'b1;
        while (m_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 32'(n < 200), 32'd1);
        @(negedge clk);
        tb_valid = 1'b0;
    endtask

    task automatic send_rec(input logic [31:0] a, input logic [31:0] d, input int maxgap);
        logic [63:0] rec;
        rec = {d, a};
        for (int i = 0; i < 8; i++) begin
            send_byte(rec[i*8 +: 8], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r1;
        logic [31:0] ra, rd;
        r1       = 64'hDEAD_BEEF_0001_1234;
        rst_a    = 1'b0;
        rst_b    = 1'b0;
        sel      = 1'b0;
        tb_valid = 1'b0;
        tb_byte  = 8'h00;
        exp_cnt  = 0;

        // Reset values while reset is held low.
        repeat (2) @(negedge clk);
        chk("rst_addr",  m_addr,  NULL_A);
        chk("rst_data",  m_data,  32'd0);
        chk("rst_ready", 32'(m_ready), 32'd0);
        chk("rst_busy",  32'(m_busy),  32'd0);
        chk("rst_done",  32'(m_done),  32'd0);
        chk("rst_count", 32'(m_count), 32'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // 1: one record streamed back to back, cycle-exact bus timing.
        wait_idle();
        mon_clear();
        for (int i = 0; i < 8; i++) begin
            tb_byte  = r1[i*8 +: 8];
            tb_valid = 1'b1;
            @(negedge clk);
        end
        tb_valid = 1'b0;
        chk("s1_d1_addr",  m_addr, 32'h0001_1234);
        chk("s1_d1_data",  m_data, 32'hDEAD_BEEF);
        chk("s1_d1_ready", 32'(m_ready), 32'd0);
        chk("s1_d1_busy",  32'(m_busy),  32'd1);
        @(negedge clk);
        chk("s1_d2_addr",  m_addr, 32'h0001_1234);
        chk("s1_d2_data",  m_data, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("s1_gap_addr",  m_addr, NULL_A);
        chk("s1_gap_data",  m_data, 32'd0);
        chk("s1_gap_ready", 32'(m_ready), 32'd0);
        chk("s1_gap_busy",  32'(m_busy),  32'd1);
        @(negedge clk);
        chk("s1_c11_ready", 32'(m_ready), 32'd1);
        chk("s1_c11_busy",  32'(m_busy),  32'd0);
        chk("s1_count",     32'(m_count), 32'd1);

        // 2: two identical records back to back.
        do_reset(1'b0);
        mon_clear();
        send_rec(32'h0000_0042, 32'h5555_AAAA, 0);
        send_rec(32'h0000_0042, 32'h5555_AAAA, 0);
        wait_idle();
        chk("s2_writes", 32'(mon_addr.size()), 32'd2);
        chk("s2_adj",    32'(adj_err), 32'd0);
        for (int i = 0; i < mon_addr.size(); i++) begin
            chk("s2_addr", mon_addr[i], 32'h0000_0042);
            chk("s2_len",  32'(mon_len[i]), 32'd2);
        end
        chk("s2_count", 32'(m_count), 32'd2);

        // 3: valid toggling, with a 20-cycle stall after byte 3.
        do_reset(1'b0);
        wait_idle();
        mon_clear();
        for (int i = 0; i < 4; i++) send_byte(r1[i*8 +: 8], 1);
        for (int i = 0; i < 20; i++) begin
            chk("s3_stall_busy", 32'(m_busy), 32'd1);
            chk("s3_stall_addr", m_addr, NULL_A);
            @(negedge clk);
        end
        send_byte(r1[39:32], 0);
        for (int i = 5; i < 8; i++) send_byte(r1[i*8 +: 8], 1);
        wait_idle();
        chk("s3_writes", 32'(mon_addr.size()), 32'd1);
        if (mon_addr.size() > 0) begin
            chk("s3_addr", mon_addr[0], 32'h0001_1234);
            chk("s3_data", mon_data[0], 32'hDEAD_BEEF);
            chk("s3_len",  32'(mon_len[0]), 32'd2);
        end
        chk("s3_count", 32'(m_count), 32'd1);

        // 4: end-of-config record, then an ignored record.
        mon_clear();
        send_rec(END_A, 32'd0, 0);
        chk("s4_done",  32'(m_done),  32'd1);
        chk("s4_ready", 32'(m_ready), 32'd0);
        chk("s4_busy",  32'(m_busy),  32'd0);
        chk("s4_addr",  m_addr, NULL_A);
        for (int i = 0; i < 24; i++) begin
            tb_byte  = r1[(i % 8)*8 +: 8];
            tb_valid = 1'b1;
            @(negedge clk);
        end
        tb_valid = 1'b0;
        @(negedge clk);
        chk("s4_writes", 32'(mon_addr.size()), 32'd0);
        chk("s4_count",  32'(m_count), 32'd1);
        chk("s4_done2",  32'(m_done),  32'd1);
        chk("s4_addr2",  m_addr, NULL_A);

        // 5: reset during the second drive cycle.
        do_reset(1'b0);
        wait_idle();
        for (int i = 0; i < 8; i++) begin
            tb_byte  = r1[i*8 +: 8];
            tb_valid = 1'b1;
            @(negedge clk);
        end
        tb_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_a = 1'b0;
        #1;
        chk("s5_addr",  m_addr, NULL_A);
        chk("s5_data",  m_data, 32'd0);
        chk("s5_count", 32'(m_count), 32'd0);
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        mon_clear();
        // A partial record followed by reset must be discarded.
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i), 0);
        repeat (5) @(negedge clk);
        chk("s5_part_busy",   32'(m_busy), 32'd1);
        chk("s5_part_writes", 32'(mon_addr.size()), 32'd0);
        do_reset(1'b0);
        send_rec(32'h0BAD_F00D, 32'h1357_9BDF, 1);
        wait_idle();
        chk("s5_writes", 32'(mon_addr.size()), 32'd1);
        if (mon_addr.size() > 0) begin
            chk("s5_raddr", mon_addr[0], 32'h0BAD_F00D);
            chk("s5_rdata", mon_data[0], 32'h1357_9BDF);
        end
        chk("s5_rcount", 32'(m_count), 32'd1);

        // Random records with random gaps against the model.
        do_reset(1'b0);
        mon_clear();
        exp_addr.delete();
        exp_data.delete();
        for (int r = 0; r < 12; r++) begin
            ra = $urandom;
            rd = $urandom;
            if (ra >= END_A) ra = 32'h1234_0000;
            exp_addr.push_back(ra);
            exp_data.push_back(rd);
            send_rec(ra, rd, 3);
        end
        wait_idle();
        chk("rnd_writes", 32'(mon_addr.size()), 32'(exp_addr.size()));
        chk("rnd_adj",    32'(adj_err), 32'd0);
        for (int i = 0; i < exp_addr.size() && i < mon_addr.size(); i++) begin
            chk("rnd_addr", mon_addr[i], exp_addr[i]);
            chk("rnd_data", mon_data[i], exp_data[i]);
            chk("rnd_len",  32'(mon_len[i]), 32'd2);
        end
        chk("rnd_count", 32'(m_count), 32'(exp_addr.size()));

        // 6: HOLD_CYCLES=1 instance, then saturation from a preset count.
        sel = 1'b1;
        do_reset(1'b1);
        wait_idle();
        mon_clear();
        send_rec(32'h0000_0007, 32'hCAFE_0001, 0);
        wait_idle();
        chk("s6_writes", 32'(mon_addr.size()), 32'd1);
        if (mon_addr.size() > 0) begin
            chk("s6_addr", mon_addr[0], 32'h0000_0007);
            chk("s6_len",  32'(mon_len[0]), 32'd1);
        end
        chk("s6_count", 32'(m_count), 32'd1);
        force dut_b.record_count_q = 16'hFFFD;
        @(negedge clk);
        release dut_b.record_count_q;
        @(negedge clk);
        chk("s6_preset", 32'(m_count), 32'h0000_FFFD);
        exp_cnt = 32'hFFFD;
        for (int i = 0; i < 3; i++) begin
            send_rec(32'h0000_0100 + 32'(i), $urandom, 1);
            wait_idle();
            exp_cnt = (exp_cnt + 1 > 32'hFFFF) ? 32'hFFFF : exp_cnt + 1;
            chk("s6_sat_count", 32'(m_count), 32'(exp_cnt));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
